// File: rtl/gamepad_pkg.sv
// Shared types and protocol constants for the serial gamepad scanner.
package gamepad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LATCH,
    GAP,
    BIT_HI,
    BIT_LO,
    COMMIT
  } state_t;

  localparam int SETUP_TICKS = 2;
  localparam int LATCH_TICKS = 2;
  localparam int GAP_TICKS   = 1;
  localparam int BITS        = 16;

endpackage

// File: rtl/gamepad_tick.sv
// Free-running divider: one-cycle tick strobe every DIV+1 clk cycles.
module gamepad_tick #(
  parameter int DIV = 15
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(DIV));

endmodule

// File: rtl/gamepad.sv
// Serial NES/SNES gamepad scanner: walks every select group, shifts in 16 bits
// per data line into a shadow frame and publishes the whole frame atomically.
module gamepad
  import gamepad_pkg::*;
#(
  parameter int DIV        = 15,
  parameter int SEL_WIDTH  = 1,
  parameter int DATA_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic [SEL_WIDTH-1:0]                  gp_sel,
  input  logic [DATA_WIDTH-1:0]                 gp_data,
  output logic                                  gp_latch,
  output logic                                  gp_clk,
  output logic [16*DATA_WIDTH*(2**SEL_WIDTH)-1:0] gp_value,
  input  logic                                  ctrl_run
);
  localparam int WORDS = DATA_WIDTH * (2**SEL_WIDTH);
  localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic                        tick;
  logic [DATA_WIDTH-1:0]       data_meta;
  logic [DATA_WIDTH-1:0]       data_sync;
  state_t                      state;
  state_t                      state_n;
  logic [1:0]                  ph_cnt;
  logic [1:0]                  ph_cnt_n;
  logic [3:0]                  bit_cnt;
  logic [3:0]                  bit_cnt_n;
  logic [SEL_WIDTH-1:0]        sel_n;
  logic                        latch_n;
  logic                        pclk_n;
  logic                        sample;
  logic                        commit;
  logic [WORDS-1:0][BITS-1:0]  shadow;

  gamepad_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Pad data is asynchronous to clk, so it only enters the design through two flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta <= '1;
      data_sync <= '1;
    end else begin
      data_meta <= gp_data;
      data_sync <= data_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      bit_cnt  <= '0;
      gp_sel   <= '0;
      gp_latch <= 1'b0;
      gp_clk   <= 1'b1;
    end else begin
      state    <= state_n;
      ph_cnt   <= ph_cnt_n;
      bit_cnt  <= bit_cnt_n;
      gp_sel   <= sel_n;
      gp_latch <= latch_n;
      gp_clk   <= pclk_n;
    end
  end

  // Pad lines are computed for the next state so they come straight off flops.
  always_comb begin
    state_n   = state;
    ph_cnt_n  = ph_cnt;
    bit_cnt_n = bit_cnt;
    sel_n     = gp_sel;
    latch_n   = gp_latch;
    pclk_n    = gp_clk;
    sample    = 1'b0;
    commit    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (ctrl_run) begin
            sel_n    = '0;
            state_n  = SETUP;
            ph_cnt_n = '0;
            latch_n  = 1'b0;
            pclk_n   = 1'b1;
          end
        end
        SETUP: begin
          if (ph_cnt == 2'(SETUP_TICKS - 1)) begin
            state_n  = LATCH;
            ph_cnt_n = '0;
            latch_n  = 1'b1;
          end else begin
            ph_cnt_n = ph_cnt + 2'd1;
          end
        end
        LATCH: begin
          if (ph_cnt == 2'(LATCH_TICKS - 1)) begin
            state_n  = GAP;
            ph_cnt_n = '0;
            latch_n  = 1'b0;
          end else begin
            ph_cnt_n = ph_cnt + 2'd1;
          end
        end
        GAP: begin
          if (ph_cnt == 2'(GAP_TICKS - 1)) begin
            state_n   = BIT_HI;
            ph_cnt_n  = '0;
            bit_cnt_n = '0;
          end else begin
            ph_cnt_n = ph_cnt + 2'd1;
          end
        end
        BIT_HI: begin
          sample  = 1'b1;
          state_n = BIT_LO;
          pclk_n  = 1'b0;
        end
        BIT_LO: begin
          pclk_n = 1'b1;
          if (bit_cnt == 4'(BITS - 1)) begin
            if (&gp_sel) begin
              state_n = COMMIT;
            end else begin
              sel_n    = gp_sel + 1'b1;
              state_n  = SETUP;
              ph_cnt_n = '0;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            state_n   = BIT_HI;
          end
        end
        COMMIT: begin
          commit  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Buttons are active-low on the wire; the shadow stores 1 = pressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      gp_value <= '0;
    end else begin
      if (sample) begin
        for (int d = 0; d < DATA_WIDTH; d++) begin
          shadow[WIW'(int'(gp_sel) * DATA_WIDTH + d)][bit_cnt] <= ~data_sync[d];
        end
      end
      if (commit) begin
        gp_value <= shadow;
      end
    end
  end

endmodule

// File: tb/tb_gamepad.sv
// Directed bench for gamepad: behavioural shift-register pad model plus a
// second instance at DIV=3 to check tick scaling.
module tb_gamepad;

  logic        clk = 1'b0;
  logic        rst;
  logic        gp_sel;
  logic [1:0]  gp_data;
  logic        gp_latch;
  logic        gp_clk;
  logic [63:0] gp_value;
  logic        ctrl_run;

  logic        gp_sel_b;
  logic [1:0]  gp_data_b;
  logic        gp_latch_b;
  logic        gp_clk_b;
  logic [63:0] gp_value_b;
  logic        ctrl_run_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gamepad #(.DIV(15), .SEL_WIDTH(1), .DATA_WIDTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .gp_sel   (gp_sel),
    .gp_data  (gp_data),
    .gp_latch (gp_latch),
    .gp_clk   (gp_clk),
    .gp_value (gp_value),
    .ctrl_run (ctrl_run)
  );

  gamepad #(.DIV(3), .SEL_WIDTH(1), .DATA_WIDTH(2)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .gp_sel   (gp_sel_b),
    .gp_data  (gp_data_b),
    .gp_latch (gp_latch_b),
    .gp_clk   (gp_clk_b),
    .gp_value (gp_value_b),
    .ctrl_run (ctrl_run_b)
  );

  assign gp_data_b  = 2'b10;
  assign ctrl_run_b = 1'b1;

  // Pad model: config is snapshotted at the sel=0 latch so a frame never mixes patterns.
  logic        pad_en   = 1'b0;
  logic [15:0] pat_base = 16'h0000;
  logic        cur_en   = 1'b0;
  logic [15:0] cur_base = 16'h0000;
  logic [15:0] sr [4];

  initial for (int w = 0; w < 4; w++) sr[w] = 16'h0000;

  always @(posedge gp_latch) begin
    if (gp_sel == 1'b0) begin
      cur_en   = pad_en;
      cur_base = pat_base;
    end
    for (int w = 0; w < 4; w++) sr[w] = cur_base ^ 16'(w);
  end

  always @(posedge gp_clk) begin
    if (!gp_latch) for (int w = 0; w < 4; w++) sr[w] = sr[w] >> 1;
  end

  assign gp_data = cur_en ? ~{sr[{gp_sel, 1'b1}][0], sr[{gp_sel, 1'b0}][0]} : 2'b11;

  function automatic logic [63:0] expValue(input logic en, input logic [15:0] base);
    logic [63:0] v;
    v = '0;
    if (en) for (int w = 0; w < 4; w++) v[16*w +: 16] = base ^ 16'(w);
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic en, input logic [15:0] base);
    ctrl_run = run;
    pad_en   = en;
    pat_base = base;
  endtask

  // Protocol monitors, sampled on the falling clk edge.
  int          falls_s[2]    = '{0, 0};
  int          last_falls[2] = '{0, 0};
  int          total_falls   = 0;
  int          low_len = 0, low_min = 1000, low_max = 0;
  int          latch_rises = 0;
  logic        latch_sel_hist[4];
  logic        last_latch_sel = 1'b0;
  int          commit_cnt = 0;
  logic [63:0] prev_value = '0;
  logic        prev_clk = 1'b1, prev_latch = 1'b0;
  int          low_len_b = 0, low_min_b = 1000, low_max_b = 0;
  int          hi_len_b = 0, hi_min_b = 1000, hi_max_b = 0;

  always @(negedge clk) begin
    if (rst) begin
      low_len    = 0;
      low_len_b  = 0;
      hi_len_b   = 0;
      prev_clk   = 1'b1;
      prev_latch = 1'b0;
      prev_value = gp_value;
    end else begin
      if (prev_clk && !gp_clk) begin
        falls_s[gp_sel]++;
        total_falls++;
      end
      if (!gp_clk) low_len++;
      else if (low_len > 0) begin
        if (low_len < low_min) low_min = low_len;
        if (low_len > low_max) low_max = low_len;
        low_len = 0;
      end
      if (gp_latch && !prev_latch) begin
        if (latch_rises < 4) latch_sel_hist[latch_rises] = gp_sel;
        latch_rises++;
        last_latch_sel = gp_sel;
        if (gp_sel == 1'b0) begin
          last_falls = falls_s;
          falls_s    = '{0, 0};
        end
      end
      if (gp_value !== prev_value) begin
        commit_cnt++;
        checkOutput("commit_value", gp_value, expValue(cur_en, cur_base));
      end
      if (!gp_clk_b) low_len_b++;
      else if (low_len_b > 0) begin
        if (low_len_b < low_min_b) low_min_b = low_len_b;
        if (low_len_b > low_max_b) low_max_b = low_len_b;
        low_len_b = 0;
      end
      if (gp_latch_b) hi_len_b++;
      else if (hi_len_b > 0) begin
        if (hi_len_b < hi_min_b) hi_min_b = hi_len_b;
        if (hi_len_b > hi_max_b) hi_max_b = hi_len_b;
        hi_len_b = 0;
      end
      prev_clk   = gp_clk;
      prev_latch = gp_latch;
      prev_value = gp_value;
    end
  end

  task automatic waitCommit(input string tag);
    int c0 = commit_cnt;
    int n  = 0;
    while (commit_cnt == c0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(commit_cnt != c0), 64'd1);
  endtask

  task automatic waitLatch(input string tag);
    int r0 = latch_rises;
    int n  = 0;
    while (latch_rises == r0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(latch_rises != r0), 64'd1);
  endtask

  initial begin
    int n;
    int f0, l0;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    repeat (20) @(negedge clk);
    checkOutput("rst_sel",   64'(gp_sel),   64'd0);
    checkOutput("rst_latch", 64'(gp_latch), 64'd0);
    checkOutput("rst_clk",   64'(gp_clk),   64'd1);
    checkOutput("rst_value", gp_value,      64'd0);
    rst = 1'b0;

    // First latch: IDLE tick, two SETUP ticks, so 48..64 cycles after release.
    n = 0;
    while (!gp_latch && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latch_delay_in_window", 64'(n >= 48 && n <= 64), 64'd1);

    n = 0;
    while (latch_rises < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("third_latch_seen", 64'(latch_rises >= 3), 64'd1);
    checkOutput("latch1_sel",    64'(latch_sel_hist[0]), 64'd0);
    checkOutput("latch2_sel",    64'(latch_sel_hist[1]), 64'd1);
    checkOutput("falls_sel0",    64'(last_falls[0]),     64'd16);
    checkOutput("falls_sel1",    64'(last_falls[1]),     64'd16);
    checkOutput("clk_low_min",   64'(low_min),           64'd16);
    checkOutput("clk_low_max",   64'(low_max),           64'd16);
    checkOutput("value_all_off", gp_value,               64'd0);

    applyStimulus(1'b1, 1'b1, 16'hA5C3);
    waitCommit("commit_a5c3");
    for (int w = 0; w < 4; w++)
      checkOutput($sformatf("word%0d", w), 64'(gp_value[16*w +: 16]), 64'(16'hA5C3 ^ 16'(w)));

    applyStimulus(1'b1, 1'b1, 16'h1234);
    waitCommit("commit_1234");
    checkOutput("value_1234", gp_value, 64'h1237_1236_1235_1234);

    // Stop request lands in the middle of a frame that already snapshotted 0F0F.
    applyStimulus(1'b1, 1'b1, 16'h0F0F);
    n = 0;
    while (cur_base != 16'h0F0F && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0F0F);
    waitCommit("commit_after_stop");
    checkOutput("value_0f0f", gp_value, expValue(1'b1, 16'h0F0F));
    f0 = total_falls;
    l0 = latch_rises;
    repeat (400) @(negedge clk);
    checkOutput("idle_no_clk_pulses", 64'(total_falls - f0), 64'd0);
    checkOutput("idle_no_latch",      64'(latch_rises - l0), 64'd0);
    checkOutput("idle_clk_high",      64'(gp_clk),           64'd1);
    checkOutput("idle_latch_low",     64'(gp_latch),         64'd0);
    applyStimulus(1'b1, 1'b1, 16'h0F0F);
    waitLatch("relaunch_latch");
    checkOutput("relaunch_sel", 64'(last_latch_sel), 64'd0);

    // Asynchronous reset in the middle of the bit phase.
    applyStimulus(1'b1, 1'b1, 16'h5A5A);
    n = 0;
    while (falls_s[0] < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_bit_phase", 64'(falls_s[0] >= 3), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_value", gp_value,      64'd0);
    checkOutput("async_rst_sel",   64'(gp_sel),   64'd0);
    checkOutput("async_rst_latch", 64'(gp_latch), 64'd0);
    checkOutput("async_rst_clk",   64'(gp_clk),   64'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    waitCommit("commit_after_rst");
    checkOutput("value_5a5a", gp_value, expValue(1'b1, 16'h5A5A));

    checkOutput("div3_value",     gp_value_b,      64'h0000_FFFF_0000_FFFF);
    checkOutput("div3_clk_low_min", 64'(low_min_b), 64'd4);
    checkOutput("div3_clk_low_max", 64'(low_max_b), 64'd4);
    checkOutput("div3_latch_min",   64'(hi_min_b),  64'd8);
    checkOutput("div3_latch_max",   64'(hi_max_b),  64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
